// File: rtl/clock_time_ctrl_pkg.sv
// ============================================================================
// Module : clock_time_ctrl_pkg
// Brief  : Shared mode encodings, edit-field masks and BCD helpers for the
//          clock time-keeping controller.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package clock_time_ctrl_pkg;

   typedef enum logic [1:0] {
      MODE_RUN      = 2'd0,
      MODE_SET_HOUR = 2'd1,
      MODE_SET_MIN  = 2'd2,
      MODE_SET_SEC  = 2'd3
   } mode_e;

   localparam logic [2:0] SEL_NONE = 3'b000;
   localparam logic [2:0] SEL_HOUR = 3'b100;
   localparam logic [2:0] SEL_MIN  = 3'b010;
   localparam logic [2:0] SEL_SEC  = 3'b001;

   localparam logic [7:0] SEC_MAX = 8'h59;
   localparam logic [7:0] MIN_MAX = 8'h59;

   // Next BCD code without range limit; the caller handles the modulus wrap.
   function automatic logic [7:0] bcd_succ(input logic [7:0] v);
      logic [7:0] r;
      if (v[3:0] == 4'd9) r = {v[7:4] + 4'd1, 4'd0};
      else                r = {v[7:4], v[3:0] + 4'd1};
      return r;
   endfunction

   function automatic logic [2:0] sel_of(input mode_e m);
      logic [2:0] r;
      case (m)
         MODE_SET_HOUR: r = SEL_HOUR;
         MODE_SET_MIN:  r = SEL_MIN;
         MODE_SET_SEC:  r = SEL_SEC;
         default:       r = SEL_NONE;
      endcase
      return r;
   endfunction

endpackage

`default_nettype wire

// File: rtl/clock_time_ctrl_if.sv
// ============================================================================
// Module : clock_time_ctrl_if
// Brief  : Key/tick inputs and time/mode outputs of the time-keeping block.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface clock_time_ctrl_if;
   logic       clk_1hz_in;
   logic       key_mode;
   logic       key_inc;
   logic [7:0] hour_bcd;
   logic [7:0] min_bcd;
   logic [7:0] sec_bcd;
   logic [1:0] mode;
   logic [2:0] set_sel;
   logic       sec_tick;
   logic       day_pulse;

   modport master (
      output clk_1hz_in, key_mode, key_inc,
      input  hour_bcd, min_bcd, sec_bcd, mode, set_sel, sec_tick, day_pulse
   );

   modport slave (
      input  clk_1hz_in, key_mode, key_inc,
      output hour_bcd, min_bcd, sec_bcd, mode, set_sel, sec_tick, day_pulse
   );
endinterface

`default_nettype wire

// File: rtl/bcd_mod_counter.sv
// ============================================================================
// Module : bcd_mod_counter
// Brief  : 8-bit two-digit BCD counter modulo MOD with increment, clear and a
//          combinational carry when incrementing from MOD-1.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module bcd_mod_counter
   import clock_time_ctrl_pkg::*;
#(
   parameter int MOD = 60
) (
   input  wire logic       clk_i,
   input  wire logic       rst_ni,
   input  wire logic       inc_i,
   input  wire logic       clr_i,
   output logic [7:0]      value_o,
   output logic            carry_o
);

   localparam int         C_MAXV    = MOD - 1;
   localparam logic [7:0] C_MAX_BCD = 8'(((C_MAXV / 10) << 4) | (C_MAXV % 10));

   logic [7:0] value_q;
   logic [7:0] value_d;
   logic       w_at_max;

   assign w_at_max = (value_q == C_MAX_BCD);
   assign carry_o  = inc_i & ~clr_i & w_at_max;
   assign value_o  = value_q;

   // Clear dominates so a field reset can never be masked by a same-cycle increment.
   always_comb begin
      value_d = value_q;
      if (clr_i)       value_d = 8'h00;
      else if (inc_i)  value_d = w_at_max ? 8'h00 : bcd_succ(value_q);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) value_q <= 8'h00;
      else         value_q <= value_d;
   end

endmodule

`default_nettype wire

// File: rtl/clock_time_ctrl.sv
// ============================================================================
// Module : clock_time_ctrl
// Brief  : 1 Hz tick extraction, BCD hh:mm:ss sequencing and set-time FSM.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module clock_time_ctrl
   import clock_time_ctrl_pkg::*;
#(
   parameter int HOUR_MOD    = 24,
   parameter int SYNC_STAGES = 2
) (
   input  wire logic          CLK,
   input  wire logic          RST,
   clock_time_ctrl_if.slave   bus
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   hist_q;
   logic                   tick_q;
   logic                   day_q;
   logic [2:0]             sel_q;
   mode_e                  state_q;
   mode_e                  state_d;

   logic       w_run_tick;
   logic       w_inc_ok;
   logic       w_sec_clr;
   logic       w_min_inc;
   logic       w_hour_inc;
   logic       w_sec_carry;
   logic       w_min_carry;
   logic       w_hour_carry;
   logic [7:0] w_sec;
   logic [7:0] w_min;
   logic [7:0] w_hour;

   // Ticks only advance time in RUN; a mode press in the same cycle still sees RUN here.
   assign w_run_tick = tick_q & (state_q == MODE_RUN);
   assign w_inc_ok   = bus.key_inc & ~bus.key_mode;
   assign w_sec_clr  = w_inc_ok & (state_q == MODE_SET_SEC);
   assign w_min_inc  = (w_run_tick & w_sec_carry) | (w_inc_ok & (state_q == MODE_SET_MIN));
   assign w_hour_inc = (w_run_tick & w_min_carry) | (w_inc_ok & (state_q == MODE_SET_HOUR));

   bcd_mod_counter #(.MOD(60)) u_sec (
      .clk_i   (CLK),
      .rst_ni  (RST),
      .inc_i   (w_run_tick),
      .clr_i   (w_sec_clr),
      .value_o (w_sec),
      .carry_o (w_sec_carry)
   );

   bcd_mod_counter #(.MOD(60)) u_min (
      .clk_i   (CLK),
      .rst_ni  (RST),
      .inc_i   (w_min_inc),
      .clr_i   (1'b0),
      .value_o (w_min),
      .carry_o (w_min_carry)
   );

   bcd_mod_counter #(.MOD(HOUR_MOD)) u_hour (
      .clk_i   (CLK),
      .rst_ni  (RST),
      .inc_i   (w_hour_inc),
      .clr_i   (1'b0),
      .value_o (w_hour),
      .carry_o (w_hour_carry)
   );

   always_comb begin
      state_d = state_q;
      if (bus.key_mode) begin
         case (state_q)
            MODE_RUN:      state_d = MODE_SET_HOUR;
            MODE_SET_HOUR: state_d = MODE_SET_MIN;
            MODE_SET_MIN:  state_d = MODE_SET_SEC;
            default:       state_d = MODE_RUN;
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         sync_q  <= '0;
         hist_q  <= 1'b0;
         tick_q  <= 1'b0;
         day_q   <= 1'b0;
         sel_q   <= SEL_NONE;
         state_q <= MODE_RUN;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], bus.clk_1hz_in};
         hist_q  <= sync_q[SYNC_STAGES-1];
         tick_q  <= sync_q[SYNC_STAGES-1] & ~hist_q;
         day_q   <= w_run_tick & w_hour_carry;
         sel_q   <= sel_of(state_d);
         state_q <= state_d;
      end
   end

   assign bus.hour_bcd  = w_hour;
   assign bus.min_bcd   = w_min;
   assign bus.sec_bcd   = w_sec;
   assign bus.mode      = state_q;
   assign bus.set_sel   = sel_q;
   assign bus.sec_tick  = tick_q;
   assign bus.day_pulse = day_q;

endmodule

`default_nettype wire
